// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data memory with valid/ready request, wait states and fault checks
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [31:0] addr,
  input  logic [2:0]  RW_type,
  input  logic [31:0] din,
  output logic        resp_valid,
  output logic [31:0] dout,
  output logic        err
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        ready_en;
  logic [3:0]  cnt;
  logic [31:0] addr_q, din_q;
  logic [2:0]  type_q;
  logic        wr_q;
  logic        accept, commit;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ready_en;
        if (ready_en && req_valid && (W_en || R_en)) begin
          accept = 1'b1;
          if (WS == 4'd0) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign resp_valid = (state == S_RESP);

  // With zero wait states the access commits on the accept edge, so use live inputs in IDLE.
  logic [31:0] op_addr, op_din;
  logic [2:0]  op_type;
  logic        op_wr;

  assign op_addr = (state == S_IDLE) ? addr    : addr_q;
  assign op_din  = (state == S_IDLE) ? din     : din_q;
  assign op_type = (state == S_IDLE) ? RW_type : type_q;
  assign op_wr   = (state == S_IDLE) ? W_en    : wr_q;

  logic [31:0]           offset;
  logic                  in_range, illegal, misal, fault;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;

  assign offset   = op_addr - BASE_ADDR;
  assign in_range = (offset[31:ADDR_WIDTH+2] == '0);
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign lane     = offset[1:0];

  always_comb begin
    illegal = 1'b1;
    case (op_type)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = ((op_type[1:0] == 2'b01) && lane[0]) ||
                 ((op_type == 3'b010) && (lane != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign fault = !in_range || illegal || misal;

  logic [31:0] rd_word, rd_shift, load_data;
  logic [15:0] rd_half;

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (op_type)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;

  always_comb begin
    be    = 4'b0000;
    wdata = op_din;
    case (op_type[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{op_din[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op_din[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign we = commit && op_wr && !fault;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
      cnt      <= 4'd0;
      addr_q   <= 32'h0;
      din_q    <= 32'h0;
      type_q   <= 3'b000;
      wr_q     <= 1'b0;
      dout     <= 32'h0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        addr_q <= addr;
        din_q  <= din;
        type_q <= RW_type;
        wr_q   <= W_en;
        cnt    <= WS - 4'd1;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err  <= fault;
        dout <= (op_wr || fault) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

  localparam int AW = 10;
  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, W_en, R_en;
  logic        req_ready, resp_valid, err;
  logic [31:0] addr, din, dout;
  logic [2:0]  RW_type;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] r_dout;
  logic        r_err;
  logic        seen;

  dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .W_en(W_en), .R_en(R_en), .addr(addr), .RW_type(RW_type), .din(din),
    .resp_valid(resp_valid), .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, check latency and single-cycle pulse, capture the response.
  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; W_en = w; R_en = r; addr = a; RW_type = t; din = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; W_en = 1'b0; R_en = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1'b1;
    end
    check({tag, ".latency"}, lat, WS + 1);
    r_dout = dout;
    r_err  = err;
    @(negedge clk);
    check({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; W_en = 1'b0; R_en = 1'b0;
    addr = 32'h0; RW_type = 3'b010; din = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.req_ready", {31'h0, req_ready}, 32'h0);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.dout", dout, 32'h0);
    check("rst.err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst.ready_before_edge", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check("rst.ready_after_edge", {31'h0, req_ready}, 32'h1);

    // Request with neither enable is ignored
    req_valid = 1'b1;
    @(negedge clk);
    check("noop.ready", {31'h0, req_ready}, 32'h1);
    check("noop.resp", {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;

    // First-store latency with req_ready dropped during WAIT
    @(negedge clk);
    req_valid = 1'b1; W_en = 1'b1; addr = 32'h10; RW_type = 3'b010; din = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; W_en = 1'b0;
    @(negedge clk);
    check("sw10.wait_ready", {31'h0, req_ready}, 32'h0);
    check("sw10.cycle1_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("sw10.cycle2_resp", {31'h0, resp_valid}, 32'h1);
    check("sw10.err", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("sw10.cycle3_resp", {31'h0, resp_valid}, 32'h0);

    access("lw10", 0, 1, 32'h10, 3'b010, 0);
    check("lw10.dout", r_dout, 32'hDEADBEEF);
    check("lw10.err", {31'h0, r_err}, 32'h0);

    access("sb11", 1, 0, 32'h11, 3'b000, 32'h55);
    access("lb11", 0, 1, 32'h11, 3'b000, 0);
    check("lb11.dout", r_dout, 32'h00000055);
    access("sb12", 1, 0, 32'h12, 3'b000, 32'h80);
    access("lb12", 0, 1, 32'h12, 3'b000, 0);
    check("lb12.dout", r_dout, 32'hFFFFFF80);
    access("lbu12", 0, 1, 32'h12, 3'b100, 0);
    check("lbu12.dout", r_dout, 32'h00000080);
    access("lw10b", 0, 1, 32'h10, 3'b010, 0);
    check("lw10b.dout", r_dout, 32'hDE8055EF);

    access("sw20", 1, 0, 32'h20, 3'b010, 32'h11223344);
    access("sh22", 1, 0, 32'h22, 3'b001, 32'h00009ABC);
    access("lh22", 0, 1, 32'h22, 3'b001, 0);
    check("lh22.dout", r_dout, 32'hFFFF9ABC);
    access("lhu22", 0, 1, 32'h22, 3'b101, 0);
    check("lhu22.dout", r_dout, 32'h00009ABC);
    access("lw20", 0, 1, 32'h20, 3'b010, 0);
    check("lw20.dout", r_dout, 32'h9ABC3344);
    access("lbu21", 0, 1, 32'h21, 3'b100, 0);
    check("lbu21.dout", r_dout, 32'h00000033);

    // Out-of-range accesses fault and never write
    access("sw0", 1, 0, 32'h0, 3'b010, 32'h0BADF00D);
    access("lw1000", 0, 1, 32'h1000, 3'b010, 0);
    check("lw1000.err", {31'h0, r_err}, 32'h1);
    check("lw1000.dout", r_dout, 32'h0);
    access("sw1000", 1, 0, 32'h1000, 3'b010, 32'hFFFFFFFF);
    check("sw1000.err", {31'h0, r_err}, 32'h1);
    access("lw0", 0, 1, 32'h0, 3'b010, 0);
    check("lw0.dout", r_dout, 32'h0BADF00D);
    check("lw0.err", {31'h0, r_err}, 32'h0);

    access("lw12", 0, 1, 32'h12, 3'b010, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw12.err", {31'h0, r_err}, 32'h1);
    check("lw12.dout", r_dout, 32'h0);
`else
    check("lw12.err", {31'h0, r_err}, 32'h0);
    check("lw12.dout", r_dout, 32'hDE8055EF);
`endif

    access("lw10c", 0, 1, 32'h10, 3'b010, 0);
    access("illegal", 0, 1, 32'h10, 3'b011, 0);
    check("illegal.err", {31'h0, r_err}, 32'h1);
    check("illegal.dout", r_dout, 32'h0);

    // Both enables: a store with dout forced to zero
    access("lw10d", 0, 1, 32'h10, 3'b010, 0);
    access("both40", 1, 1, 32'h40, 3'b010, 32'hCAFEF00D);
    check("both40.dout", r_dout, 32'h0);
    check("both40.err", {31'h0, r_err}, 32'h0);
    access("lw40", 0, 1, 32'h40, 3'b010, 0);
    repeat (3) @(negedge clk);
    check("lw40.hold", dout, 32'hCAFEF00D);

    // Reset during WAIT abandons the store
    access("sw30", 1, 0, 32'h30, 3'b010, 32'hA5A5A5A5);
    access("lw30", 0, 1, 32'h30, 3'b010, 0);
    check("lw30.dout", r_dout, 32'hA5A5A5A5);
    @(negedge clk);
    req_valid = 1'b1; W_en = 1'b1; addr = 32'h30; RW_type = 3'b010; din = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0; W_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.dout", dout, 32'h0);
    check("midrst.err", {31'h0, err}, 32'h0);
    check("midrst.ready", {31'h0, req_ready}, 32'h0);
    check("midrst.resp", {31'h0, resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("midrst.no_resp", {31'h0, seen}, 32'h0);
    access("lw30b", 0, 1, 32'h30, 3'b010, 0);
    check("lw30b.dout", r_dout, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, multi-cycle successor to the single-cycle data memory behind the riscv core.
- Adds a valid/ready request handshake, configurable wait states, range and misalignment checking, and a registered response.
- The core stalls on req_ready and resp_valid.
- Byte/half/word access uses the same RW_type encoding the core already drives.

Parameters:
- ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request this cycle
- W_en  input  1  store request
- R_en  input  1  load request
- addr  input  32  byte address
- RW_type  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
- din  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse; dout and err are valid
- dout  output  32  load data, extended per RW_type
- err  output  1  access fault; qualified by resp_valid

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n is low:
  - state goes to IDLE;
  - resp_valid=0, dout=0, err=0, req_ready=0.
  - Memory array contents are not cleared.
  - A pending access is abandoned: no write commits.
  - req_ready=1 from the first clk edge after rst_n rises.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept happens when req_valid & (W_en | R_en). addr, RW_type, din and the op are captured. Next state is WAIT if WAIT_STATES>0, else RESP.
  - req_valid with W_en=R_en=0 is ignored; state stays IDLE.
  - WAIT: 4-bit counter runs WAIT_STATES cycles; req_ready=0. Moves to RESP at the edge the count expires.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0. Next state is IDLE.
- Latency: request accepted at edge N gives resp_valid high in cycle N+1+WAIT_STATES. Back-to-back requests accept every WAIT_STATES+2 cycles.
- Commit: the store write and the load read sample at the edge entering RESP. A load immediately after a store returns the new data.
- W_en and R_en both high: treated as a store; dout=0.
- dout and err are registered. They hold their values after resp_valid falls, until the next response.
- Store lanes:
  - SB writes din[7:0] to byte lane addr[1:0].
  - SH writes din[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Loads:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Range: offset = addr - BASE_ADDR in 32-bit wrap-around arithmetic. If offset >= DEPTH*4, the access faults: err=1, dout=0, no write. Addresses below BASE_ADDR wrap to large offsets and fault.
- Illegal RW_type: err=1, dout=0, no write.
- Misalignment is handled per DMEM_MISALIGN_TRAP_EN (see Optional Feature).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: the following fault with err=1, dout=0, no write:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
- Undefined: misaligned low bits are silently masked and the access completes with err=0.
  - H/HU ignores addr[0].
  - W ignores addr[1:0].

Test Plan:
- WAIT_STATES=1: SW 0x0000_0010 din=0xDEADBEEF accepted at edge 0; resp_valid high only in cycle 2 with err=0; then LW 0x10 returns dout=0xDEADBEEF.
- After the above: SB 0x11 din=0x55, then LB 0x11 returns 0x00000055. SB 0x12 din=0x80, then LB 0x12 returns 0xFFFFFF80, LBU 0x12 returns 0x00000080, and LW 0x10 returns 0xDE8055EF.
- SH 0x22 din=0x0000_9ABC, then LH 0x22 returns 0xFFFF9ABC and LHU 0x22 returns 0x00009ABC. Lanes 0x20/0x21 are unchanged.
- ADDR_WIDTH=10: LW addr=0x1000 gives err=1, dout=0. SW addr=0x1000 gives err=1 and a following LW 0x0 is unchanged.
- LW 0x12:
  - with DMEM_MISALIGN_TRAP_EN defined, err=1 and dout=0;
  - without it, err=0 and dout equals the word at 0x10.
- SW 0x30 din=0x1234_5678 accepted; rst_n pulsed low in the WAIT cycle. Outputs go to 0 immediately, no resp_valid follows, and a post-reset LW 0x30 returns the pre-test value.
